// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side slice.
//   DW      - default byte width of the FIFO data path
//   state_e - fifo_drain control states
package fifo_pkg;

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: two-entry in-order holding buffer with a registered head entry.
// Ports:
//   clk, rst     clock, async active-low reset (empties the buffer)
//   push, din    write one entry (caller guarantees no push into a full buffer
//                unless the same cycle pops)
//   pop          remove the head entry (caller guarantees occ != 0)
//   head         current head entry, straight from a register
//   occ          number of valid entries, 0..2
module fifo_skid2 #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] tail;

  // Head is always entry 0; tail shifts into head on a pop so head stays a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case (occ)
        2'd0: begin
          if (push) begin
            head <= din;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail <= din;
            occ  <= 2'd2;
          end else if (pop) begin
            occ  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= din;
            else      occ  <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: read-side engine for the byte FIFO. Issues fifo_rden while the FIFO
// has data and the output buffer has credit, absorbs the FIFO's one-cycle read
// latency and presents bytes on a valid/ready stream with a burst-last flag.
// Ports:
//   clk, rst          clock, async active-low reset
//   en                1 = keep fetching; 0 = stop fetching, finish buffered bytes
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO data_out, valid the cycle after an accepted read
//   fifo_rden         FIFO read strobe (combinational)
//   m_data, m_valid   output stream payload / valid
//   m_ready           output stream ready
//   m_last            m_data is the last byte of a BURST_LEN-byte burst
//   busy              engine is not idle
//   byte_cnt          bytes delivered since reset, wrapping
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = fifo_pkg::DW,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rden,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic [CW-1:0] byte_cnt
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e        state;
  logic          in_flight;
  logic [BW-1:0] beat;
  logic [1:0]    occ;
  logic [DW:0]   head;
  logic          pop;
  logic          fetch_ok;
  logic          tag_last;

  assign pop      = m_valid & m_ready;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = head[DW-1:0];
  assign m_last   = head[DW];
  assign busy     = (state != IDLE);
  assign fetch_ok = (state == RUN) & en;

  // Credit: bytes held plus the one possibly in flight must leave room after this cycle's pop.
  assign fifo_rden = fetch_ok & ~fifo_empty &
                     ((3'(occ) + 3'(in_flight)) < (3'd2 + 3'(pop)));

  // Burst position is tagged at capture; capture order equals delivery order.
  assign tag_last = (beat == BW'(BURST_LEN - 1));

  fifo_skid2 #(.W(DW + 1)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (in_flight),
    .din  ({tag_last, fifo_data}),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  // Control state, in-flight tracking and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_flight <= 1'b0;
      beat      <= '0;
      byte_cnt  <= '0;
    end else begin
      in_flight <= fifo_rden;
      if (in_flight) beat <= tag_last ? '0 : beat + BW'(1);
      if (pop)       byte_cnt <= byte_cnt + CW'(1);
      unique case (state)
        IDLE: if (en) state <= RUN;
        RUN:  if (!en) state <= STOP;
        STOP: begin
          if (en)                                 state <= RUN;
          else if ((occ == 2'd0) && !in_flight)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: drives fifo_drain from a behavioural 8-deep FIFO and checks the
// stream against an in-order byte queue; a second instance (BURST_LEN=1, CW=4)
// fed by an always-full source covers counter wrap and single-byte bursts.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, fifo_empty, fifo_rden, m_valid, m_ready, m_last, busy;
  logic [DW-1:0] fifo_data, m_data;
  logic [CW-1:0] byte_cnt;

  logic          en2, m_ready2, rden2, m_valid2, m_last2, busy2, empty2;
  logic [DW-1:0] src_data, src_next, m_data2;
  logic [3:0]    byte_cnt2;

  fifo_drain #(.DW(DW), .BURST_LEN(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rden(fifo_rden), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .byte_cnt(byte_cnt)
  );

  fifo_drain #(.DW(DW), .BURST_LEN(1), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(empty2), .fifo_data(src_data),
    .fifo_rden(rden2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_last(m_last2), .busy(busy2), .byte_cnt(byte_cnt2)
  );

  // Behavioural FIFO with one-cycle registered read data.
  logic          wr;
  logic [7:0]    wdata;
  logic [7:0]    mem [8];
  logic [2:0]    wp, rp;
  logic [3:0]    cnt;
  logic          wr_ok, rd_ok;
  assign wr_ok      = wr && (cnt != 4'd8);
  assign rd_ok      = fifo_rden && (cnt != 4'd0);
  assign fifo_empty = (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= 3'd0; rp <= 3'd0; cnt <= 4'd0; fifo_data <= 8'd0;
    end else begin
      if (wr_ok) begin mem[wp] <= wdata; wp <= wp + 3'd1; end
      if (rd_ok) begin fifo_data <= mem[rp]; rp <= rp + 3'd1; end
      cnt <= cnt + 4'(wr_ok) - 4'(rd_ok);
    end
  end

  // Endless source for the second instance: 0,1,2,... one per read.
  assign empty2 = 1'b0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_data <= 8'd0; src_next <= 8'd0;
    end else if (rden2) begin
      src_data <= src_next; src_next <= src_next + 8'd1;
    end
  end

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: bytes written but not yet delivered, in order.
  logic [7:0] exp_q [$];
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         got_cyc [$];
  int         n = 0, pending = 0, cyc = 0, exp2 = 0, pops2 = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       c_pop, c_acc;

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      n = 0; pending = 0; prev_stall = 1'b0; exp2 = 0; pops2 = 0;
    end else begin
      c_pop = m_valid & m_ready;
      c_acc = fifo_rden & ~fifo_empty;
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data",  32'(m_data),  32'(prev_data));
        chk("stall_last",  32'(m_last),  32'(prev_last));
      end
      if (fifo_rden) begin
        chk("rden_needs_en", 32'(en), 32'd1);
        chk("rden_nonempty", 32'(fifo_empty), 32'd0);
      end
      chk("held_le2", 32'((pending + int'(c_acc) - int'(c_pop)) <= 2), 32'd1);
      if (c_pop) begin
        if (exp_q.size() == 0) begin
          chk("pop_without_data", 32'(m_valid), 32'd0);
        end else begin
          chk("data",     32'(m_data),   32'(exp_q.pop_front()));
          chk("last",     32'(m_last),   32'((n % 4) == 3));
          chk("byte_cnt", 32'(byte_cnt), 32'(16'(n)));
          got_data.push_back(m_data);
          got_last.push_back(m_last);
          got_cyc.push_back(cyc);
          n++;
        end
      end
      pending    = pending + int'(c_acc) - int'(c_pop);
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid2 && m_ready2) begin
        chk("w_data", 32'(m_data2), 32'(8'(exp2)));
        chk("w_last", 32'(m_last2), 32'd1);
        exp2++;
        pops2++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seq(input logic [7:0] start, input int num);
    for (int i = 0; i < num; i++) begin
      wdata = start + 8'(i);
      wr    = 1'b1;
      exp_q.push_back(wdata);
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic wait_log(input string name, input int target, input int budget);
    int k = 0;
    while (got_data.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_timeout"}, 32'(got_data.size() >= target), 32'd1);
  endtask

  // Delivered bytes must be start, start+1, ... with last on every 4th.
  task automatic check_log(input string name, input logic [7:0] start, input int num);
    chk({name, "_count"}, 32'(got_data.size()), 32'(num));
    for (int i = 0; i < num && i < got_data.size(); i++) begin
      chk({name, "_byte"}, 32'(got_data[i]), 32'(start + 8'(i)));
      chk({name, "_lastpos"}, 32'(got_last[i]), 32'((i % 4) == 3));
    end
  endtask

  logic pat [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    int k;
    int held;
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; wr = 1'b0; wdata = 8'd0;
    en2 = 1'b0; m_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_cnt",   32'(byte_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Reset mid-stream.
    write_seq(8'h31, 3);
    en = 1'b1;
    repeat (4) tick();
    chk("t1_busy_before", 32'(busy), 32'd1);
    chk("t1_valid_before", 32'(m_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_valid", 32'(m_valid), 32'd0);
    chk("t1_data",  32'(m_data),  32'd0);
    chk("t1_last",  32'(m_last),  32'd0);
    chk("t1_rden",  32'(fifo_rden), 32'd0);
    chk("t1_busy",  32'(busy),    32'd0);
    chk("t1_cnt",   32'(byte_cnt), 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Full-rate drain of a full FIFO.
    clear_log();
    write_seq(8'h01, 8);
    m_ready = 1'b1;
    en = 1'b1;
    tick();
    tick();
    chk("t2_not_yet_valid", 32'(m_valid), 32'd0);
    tick();
    chk("t2_first_valid", 32'(m_valid), 32'd1);
    chk("t2_first_data",  32'(m_data),  32'h01);
    wait_log("t2", 8, 20);
    check_log("t2", 8'h01, 8);
    for (int i = 1; i < got_cyc.size(); i++)
      chk("t2_back_to_back", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    repeat (2) tick();
    chk("t2_cnt",   32'(byte_cnt), 32'd8);
    chk("t2_empty", 32'(fifo_empty), 32'd1);
    chk("t2_rden",  32'(fifo_rden), 32'd0);
    chk("t2_valid", 32'(m_valid), 32'd0);

    // Backpressure pattern 1,0,0.
    en = 1'b0; m_ready = 1'b0;
    repeat (4) tick();
    clear_log();
    write_seq(8'h01, 8);
    en = 1'b1;
    k = 0;
    while (got_data.size() < 8 && k < 200) begin
      m_ready = pat[k % 3];
      tick();
      k++;
    end
    chk("t3_timeout", 32'(got_data.size() >= 8), 32'd1);
    check_log("t3", 8'h01, 8);
    chk("t3_cnt", 32'(byte_cnt), 32'd16);

    // Stop after the third byte, then resume.
    en = 1'b0; m_ready = 1'b1;
    repeat (4) tick();
    clear_log();
    write_seq(8'h01, 8);
    en = 1'b1;
    wait_log("t4_first3", 3, 20);
    en = 1'b0;
    tick();
    chk("t4_stop_busy", 32'(busy), 32'd1);
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk("t4_idle", 32'(busy), 32'd0);
    held = got_data.size();
    chk("t4_extra_le2", 32'(held <= 5), 32'd1);
    repeat (3) tick();
    chk("t4_no_more_while_idle", 32'(got_data.size() == held), 32'd1);
    en = 1'b1;
    wait_log("t4_rest", 8, 40);
    check_log("t4", 8'h01, 8);
    chk("t4_cnt", 32'(byte_cnt), 32'd24);

    // Empty gap while running.
    en = 1'b0;
    repeat (4) tick();
    clear_log();
    write_seq(8'hA1, 2);
    en = 1'b1;
    wait_log("t5_first2", 2, 20);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_gap_valid", 32'(m_valid), 32'd0);
      chk("t5_gap_busy",  32'(busy),    32'd1);
      tick();
    end
    write_seq(8'hA3, 2);
    wait_log("t5_all", 4, 20);
    check_log("t5", 8'hA1, 4);
    chk("t5_cnt", 32'(byte_cnt), 32'd28);
    en = 1'b0;

    // Counter wrap and single-byte bursts on the second instance.
    chk("t6_cnt_start", 32'(byte_cnt2), 32'd0);
    en2 = 1'b1; m_ready2 = 1'b1;
    k = 0;
    while (pops2 < 15 && k < 60) begin tick(); k++; end
    chk("t6_cnt_15", 32'(byte_cnt2), 32'd15);
    k = 0;
    while (pops2 < 17 && k < 20) begin tick(); k++; end
    chk("t6_cnt_wrap", 32'(byte_cnt2), 32'd1);
    en2 = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
